// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Scan controller for a 4-digit multiplexed 7-segment display that shows
// either the mm:ss or the hh:mm part of a BCD hh:mm:ss time count. It walks an
// active-low one-hot digit select, picks the BCD nibble for the selected
// digit from a per-frame snapshot of the time, and (optionally) blinks one
// time field while the user is setting the clock.
//
// Optional feature: define SEG_BLINK_EN to build the field blink logic
// (frame counter, blink phase, latched blink field). Without it `blank` is
// tied low and `blink_field` is ignored.
//
// Parameters:
//   SCAN_DIV      clock cycles each digit is held (>= 2)
//   BLINK_FRAMES  frames per blink half-period (>= 1, blink build only)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   count[23:0]  in   BCD time {hh_t,hh_u,mm_t,mm_u,ss_t,ss_u}
//   page_req     in   0 = show mm:ss, 1 = show hh:mm (applied at frame start)
//   blink_field  in   00 none, 01 seconds, 10 minutes, 11 hours
//   sel[3:0]     out  active-low one-hot digit enable, 1110 = rightmost
//   x[3:0]       out  BCD nibble for the selected digit
//   blank        out  1 = selected digit must be dark
//   dp           out  colon / decimal point, high while digit 2 is selected
//   page         out  page currently displayed
//   frame_done   out  one-cycle pulse when digit 3 hands over to digit 0
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] count,
  input  logic        page_req,
  input  logic [1:0]  blink_field,
  output logic [3:0]  sel,
  output logic [3:0]  x,
  output logic        blank,
  output logic        dp,
  output logic        page,
  output logic        frame_done
);

  localparam int PC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Field codes, shared by blink_field and the digit ownership map.
  localparam logic [1:0] FLD_SEC  = 2'b01;
  localparam logic [1:0] FLD_MIN  = 2'b10;
  localparam logic [1:0] FLD_HOUR = 2'b11;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      sel_q, sel_d;
  logic [23:0]     snap_q, snap_d;
  logic            page_q, page_d;
  logic            frame_done_q, frame_done_d;

  logic            pc_tc;
  logic            boundary;

  assign pc_tc    = (pc_q == PC_W'(SCAN_DIV - 1));
  // The frame ends on the edge that moves the last digit back to digit 0.
  assign boundary = pc_tc && (idx_q == 2'd3);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_d         = pc_q + 1'b1;
    idx_d        = idx_q;
    sel_d        = sel_q;
    snap_d       = snap_q;
    page_d       = page_q;
    frame_done_d = 1'b0;
    if (pc_tc) begin
      pc_d  = '0;
      idx_d = idx_q + 2'd1;
      sel_d = ~(4'b0001 << idx_d);
    end
    if (boundary) begin
      snap_d       = count;
      page_d       = page_req;
      frame_done_d = 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= '0;
      idx_q        <= 2'd0;
      sel_q        <= 4'b1110;
      // NOTE: the snapshot is a data register, but it is loaded from the live
      // count during reset rather than cleared, so the first digit shown after
      // reset is already the real seconds value.
      snap_q       <= count;
      page_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      snap_q       <= snap_d;
      page_q       <= page_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Digit mux: page 1 shifts the 4-digit window up by one field (two nibbles).
  logic [2:0] nib_sel;
  assign nib_sel = {1'b0, idx_q} + (page_q ? 3'd2 : 3'd0);

  always_comb begin
    x = 4'h0;
    case (nib_sel)
      3'd0:    x = snap_q[3:0];
      3'd1:    x = snap_q[7:4];
      3'd2:    x = snap_q[11:8];
      3'd3:    x = snap_q[15:12];
      3'd4:    x = snap_q[19:16];
      3'd5:    x = snap_q[23:20];
      default: x = 4'h0;
    endcase
  end

  assign sel        = sel_q;
  assign dp         = (idx_q == 2'd2);
  assign page       = page_q;
  assign frame_done = frame_done_q;

`ifdef SEG_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic            phase_q, phase_d;
  logic [1:0]      fld_q, fld_d;
  logic [1:0]      owner;

  // The frame counter advances on the boundary edge itself, so a new phase
  // becomes visible together with the first digit of the new frame.
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    fld_d   = fld_q;
    if (boundary) begin
      fld_d = blink_field;
      if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
      fld_q   <= 2'b00;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      fld_q   <= fld_d;
    end
  end

  // Field shown by the selected digit: low pair / high pair of the window.
  always_comb begin
    if (page_q) owner = idx_q[1] ? FLD_HOUR : FLD_MIN;
    else        owner = idx_q[1] ? FLD_MIN  : FLD_SEC;
  end

  assign blank = phase_q && (fld_q != 2'b00) && (fld_q == owner);
`else
  logic unused_blink;
  assign unused_blink = ^blink_field;
  assign blank        = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Self-checking bench for seg_scan_ctrl. A behavioural model tracks the cycle
// number since reset release, the frame snapshot, the displayed page, the
// latched blink field and the number of completed frames; every expected
// output is derived from those with plain arithmetic. Directed sequences with
// hand-computed literal values are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int S     = 4;
  localparam int BF    = 2;
  localparam int FRAME = 4 * S;
`ifdef SEG_BLINK_EN
  localparam logic BLINK = 1'b1;
`else
  localparam logic BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] count = 24'h123456;
  logic        page_req = 1'b0;
  logic [1:0]  blink_field = 2'b00;
  logic [3:0]  sel;
  logic [3:0]  x;
  logic        blank;
  logic        dp;
  logic        page;
  logic        frame_done;

  seg_scan_ctrl #(.SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .count       (count),
    .page_req    (page_req),
    .blink_field (blink_field),
    .sel         (sel),
    .x           (x),
    .blank       (blank),
    .dp          (dp),
    .page        (page),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int          t = 0;          // cycle number since reset release
  logic [23:0] m_snap = 24'h123456;
  logic        m_page = 1'b0;
  logic [1:0]  m_fld = 2'b00;
  int          m_frames = 0;   // frames completed since reset

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, t, got, exp);
    end
  endtask

  function automatic int m_idx();
    return (t / S) % 4;
  endfunction

  function automatic logic [3:0] m_x();
    int pos;
    pos = m_idx() + (m_page ? 2 : 0);
    return m_snap[pos*4 +: 4];
  endfunction

  function automatic logic m_blank();
    int field;
    int phase;
    if (!BLINK) return 1'b0;
    phase = (m_frames / BF) % 2;
    if (m_page) field = (m_idx() < 2) ? 2 : 3;
    else        field = (m_idx() < 2) ? 1 : 2;
    return (phase == 1) && (m_fld != 2'b00) && (int'(m_fld) == field);
  endfunction

  // Compare all outputs for the current cycle, then drive the inputs for the
  // next edge and advance the model across that edge.
  task automatic tick(input logic r, input logic [23:0] c, input logic p, input logic [1:0] b);
    logic [3:0] exp_sel;
    @(negedge clk);
    exp_sel = ~(4'b0001 << m_idx());
    check("sel", sel, exp_sel);
    check("x", x, m_x());
    check("dp", dp, m_idx() == 2);
    check("blank", blank, m_blank());
    check("page", page, m_page);
    check("frame_done", frame_done, (t != 0) && (t % FRAME == 0));
    rst_n       = r;
    count       = c;
    page_req    = p;
    blink_field = b;
    if (!r) begin
      t        = 0;
      m_snap   = c;
      m_page   = 1'b0;
      m_fld    = 2'b00;
      m_frames = 0;
    end else begin
      t++;
      if (t % FRAME == 0) begin
        m_snap = c;
        m_page = p;
        m_fld  = b;
        m_frames++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout cycle=%0d", t);
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] rc;
    logic        rp;
    logic [1:0]  rb;

    repeat (2) @(posedge clk);
    tick(1'b0, 24'h123456, 1'b0, 2'b00);

    // Scan order, page switch at cycle 5, count change at cycle 9.
    for (int c = 0; c < 42; c++) begin
      tick(1'b1, (c >= 9) ? 24'h235959 : 24'h123456, c >= 5, 2'b00);
      case (c)
        0:  begin check("pin_sel_c0", sel, 4'b1110); check("pin_x_c0", x, 4'h6);
                  check("pin_dp_c0", dp, 1'b0); end
        4:  begin check("pin_sel_c4", sel, 4'b1101); check("pin_x_c4", x, 4'h5); end
        5:  check("pin_page_c5", page, 1'b0);
        8:  begin check("pin_sel_c8", sel, 4'b1011); check("pin_x_c8", x, 4'h4);
                  check("pin_dp_c8", dp, 1'b1); end
        12: begin check("pin_sel_c12", sel, 4'b0111); check("pin_x_c12", x, 4'h3); end
        15: check("pin_fd_c15", frame_done, 1'b0);
        16: begin check("pin_fd_c16", frame_done, 1'b1); check("pin_page_c16", page, 1'b1);
                  check("pin_x_c16", x, 4'h9); check("pin_sel_c16", sel, 4'b1110); end
        20: check("pin_x_c20", x, 4'h5);
        24: check("pin_x_c24", x, 4'h3);
        28: check("pin_x_c28", x, 4'h2);
        default: ;
      endcase
    end

    // Mid-frame reset at cycle 42 (10 cycles into the third frame).
    tick(1'b0, 24'h000007, 1'b1, 2'b00);
    for (int k = 0; k <= 16; k++) begin
      tick(1'b1, 24'h000007, 1'b1, 2'b00);
      case (k)
        0:  begin check("pin_rst_sel", sel, 4'b1110); check("pin_rst_x", x, 4'h7);
                  check("pin_rst_fd", frame_done, 1'b0); check("pin_rst_blank", blank, 1'b0); end
        15: check("pin_rst_fd15", frame_done, 1'b0);
        16: check("pin_rst_fd16", frame_done, 1'b1);
        default: ;
      endcase
    end

    // Blink seconds on page 0 for 9 frames.
    tick(1'b0, 24'h001234, 1'b0, 2'b01);
    for (int c = 0; c < 9 * FRAME; c++) begin
      tick(1'b1, 24'h001234, 1'b0, 2'b01);
      case (c)
        16: check("pin_blank_f1", blank, 1'b0);
        32: check("pin_blank_f2d0", blank, BLINK);
        36: check("pin_blank_f2d1", blank, BLINK);
        40: check("pin_blank_f2d2", blank, 1'b0);
        64: check("pin_blank_f4", blank, 1'b0);
        96: check("pin_blank_f6", blank, BLINK);
        default: ;
      endcase
    end

    // Seconds blink on page 1: seconds are not shown, so never dark.
    tick(1'b0, 24'h001234, 1'b1, 2'b01);
    for (int c = 0; c < 9 * FRAME; c++) begin
      tick(1'b1, 24'h001234, 1'b1, 2'b01);
    end

    // Randomized traffic with occasional resets.
    rc = $urandom;
    rp = 1'b0;
    rb = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      rc = $urandom;
      if ($urandom_range(7) == 0) rp = $urandom_range(1);
      if ($urandom_range(15) == 0) rb = 2'($urandom_range(3));
      tick($urandom_range(299) != 0, rc, rp, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
